// File: rtl/audio_pkg.sv
// Shared audio types and frame geometry for the I2S transmit path.
//   SAMPLE_W     : width of one mono audio sample
//   FRAME_SLOTS  : bclk slots per stereo frame (L word + R word)
//   SLOT_W       : width of the slot counter
//   audio_sample_t : signed sample as produced by the FIR decimator
//   frame_word_t   : one full stereo frame as shifted out on sdata
//   stereo_word()  : duplicate a mono sample into both channels
package audio_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int FRAME_SLOTS = 2 * SAMPLE_W;
  localparam int SLOT_W      = $clog2(FRAME_SLOTS);

  typedef logic signed [SAMPLE_W-1:0] audio_sample_t;
  typedef logic [FRAME_SLOTS-1:0]     frame_word_t;

  // Mono to stereo: left word first (MSB side), right word second.
  function automatic frame_word_t stereo_word(input audio_sample_t s);
    return {s, s};
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous sample FIFO between the decimation filter and the I2S shifter.
// Pointers wrap modulo FIFO_DEPTH (power of two). A pop frees its entry in
// the same cycle, so a push against a full FIFO is accepted when a pop
// happens alongside it. A pop against an empty FIFO never bypasses the
// incoming push: the pushed sample is simply stored.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset (empties the FIFO)
//   push        : write request, push_data is the sample to store
//   pop         : read request, head is the oldest stored sample
//   full, empty : occupancy status
//   level       : number of stored entries (0..FIFO_DEPTH)
//   push_ok     : the push in this cycle is being stored
//   pop_ok      : the pop in this cycle removes head
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter  int FIFO_DEPTH = 8,
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1),
  localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  audio_sample_t    push_data,
  input  logic             pop,
  output audio_sample_t    head,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  output logic             push_ok,
  output logic             pop_ok
);

  audio_sample_t    mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign full    = (level == LVL_W'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign pop_ok  = pop & ~empty;
  // Pop is resolved first, so a full FIFO with a concurrent pop has room.
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(push_ok) - LVL_W'(pop_ok);
    end
  end

  // Storage carries data only; emptiness is tracked by the pointers/level.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter fed by the FIR decimation filter.
// Each sample_valid strobe pushes one mono sample into a small FIFO. The
// transmitter runs a free-running bit clock (BCLK_DIV clk per half period)
// and a frame of FRAME_SLOTS slots; on entry to slot 0 it pops one sample
// and sends it on both channels, MSB first, one bclk after the lrck edge.
// When the FIFO is empty at a pop the previous sample is repeated.
// Ports:
//   clk, reset    : system clock, asynchronous active-high reset
//   sample_in     : signed sample, qualified by sample_valid
//   sample_valid  : one-cycle push strobe
//   clear_flags   : synchronous clear of the sticky flags (a new event wins)
//   i2s_bclk      : bit clock
//   i2s_lrck      : word select, 0 = left, 1 = right
//   i2s_sdata     : serial data, updated on bclk falling edges
//   fifo_level    : samples currently buffered
//   overflow      : sticky, a push arrived while full and was dropped
//   underflow     : sticky, a pop happened while empty
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter  int FIFO_DEPTH = 8,
  parameter  int BCLK_DIV   = 6,
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1),
  localparam int DIV_W      = $clog2(BCLK_DIV)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  input  logic                       clear_flags,
  output logic                       i2s_bclk,
  output logic                       i2s_lrck,
  output logic                       i2s_sdata,
  output logic [LVL_W-1:0]           fifo_level,
  output logic                       overflow,
  output logic                       underflow
);

  logic [DIV_W-1:0]  div;
  logic              div_tc;
  logic              fall_evt;
  logic [SLOT_W-1:0] slot;
  logic [SLOT_W-1:0] slot_nxt;
  frame_word_t       shreg;
  audio_sample_t     last_sample;
  audio_sample_t     fifo_head;
  audio_sample_t     tx_sample;
  logic              pop_req;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push_ok;
  logic              pop_ok;
  logic              ovf_evt;
  logic              unf_evt;

  audio_sample_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (sample_valid),
    .push_data (sample_in),
    .pop       (pop_req),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .push_ok   (push_ok),
    .pop_ok    (pop_ok)
  );

  // ---- bit clock divider ----
  assign div_tc   = (div == DIV_W'(BCLK_DIV - 1));
  // A falling bclk edge is the terminal count while bclk is high.
  assign fall_evt = div_tc & i2s_bclk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div      <= '0;
      i2s_bclk <= 1'b0;
    end else if (div_tc) begin
      div      <= '0;
      i2s_bclk <= ~i2s_bclk;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // ---- slot sequencing and FIFO pop ----
  always_comb begin
    slot_nxt = slot + SLOT_W'(1);
    if (slot == SLOT_W'(FRAME_SLOTS - 1)) slot_nxt = '0;
  end

  assign pop_req   = fall_evt & (slot_nxt == '0);
  // Empty FIFO at pop time: repeat the last sample that was sent.
  assign tx_sample = pop_ok ? fifo_head : last_sample;

  // ---- serialiser ----
  // sdata always takes the current shreg MSB, so slot 0 still carries the
  // previous frame's right-channel LSB before the new word takes effect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot        <= '0;
      i2s_lrck    <= 1'b0;
      i2s_sdata   <= 1'b0;
      shreg       <= '0;
      last_sample <= '0;
    end else if (fall_evt) begin
      slot      <= slot_nxt;
      i2s_lrck  <= (slot_nxt >= SLOT_W'(SAMPLE_W));
      i2s_sdata <= shreg[FRAME_SLOTS-1];
      if (pop_req) begin
        shreg <= stereo_word(tx_sample);
        if (pop_ok) last_sample <= fifo_head;
      end else begin
        shreg <= shreg << 1;
      end
    end
  end

  // ---- sticky error flags ----
  assign ovf_evt = sample_valid & fifo_full & ~pop_ok;
  assign unf_evt = pop_req & fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_evt)          overflow <= 1'b1;
      else if (clear_flags) overflow <= 1'b0;
      if (unf_evt)          underflow <= 1'b1;
      else if (clear_flags) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx at default parameters (16-bit, depth 8, div 6).
// The reference model works from elapsed clock count since reset release:
// bclk = (c/6)%2, falling edges every 12 clk, slot = (c/12)%32, a pop every
// 384 clk; the FIFO is a queue and each frame's sent word is {s,s}.
module tb_audio_i2s_tx;

  localparam int DEPTH  = 8;
  localparam int FRAME  = 384;
  localparam int FALL   = 12;
  localparam int SLOTS  = 32;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] sample_in;
  logic               sample_valid;
  logic               clear_flags;
  logic               bclk, lrck, sdata;
  logic [3:0]         level;
  logic               ovf, unf;

  audio_i2s_tx #(.FIFO_DEPTH(DEPTH), .BCLK_DIV(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .clear_flags  (clear_flags),
    .i2s_bclk     (bclk),
    .i2s_lrck     (lrck),
    .i2s_sdata    (sdata),
    .fifo_level   (level),
    .overflow     (ovf),
    .underflow    (unf)
  );

  always #5 clk = ~clk;

  // Reference model state
  int unsigned c;
  logic [15:0] q[$];
  logic [15:0] last;
  logic [31:0] w_cur, w_prev;
  logic        m_ovf, m_unf;

  int vectors    = 0;
  int miscompares = 0;

  task automatic model_reset();
    c = 0; q.delete(); last = '0; w_cur = '0; w_prev = '0; m_ovf = 0; m_unf = 0;
  endtask

  function automatic logic [8:0] exp_vec();
    int n, k;
    logic b, lr, sd;
    n  = int'(c) / FALL;
    k  = n % SLOTS;
    b  = ((int'(c) / 6) % 2) == 1;
    lr = (k >= 16);
    if (n == 0)      sd = 1'b0;
    else if (k == 0) sd = w_prev[0];
    else             sd = w_cur[32 - k];
    return {b, lr, sd, 4'(q.size()), m_ovf, m_unf};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {bclk, lrck, sdata, level, ovf, unf};
  endfunction

  // One clock of stimulus; the model advances with the edge.
  task automatic step(input logic v, input logic [15:0] d, input logic clr);
    logic [15:0] s;
    sample_valid = v; sample_in = d; clear_flags = clr;
    @(posedge clk);
    c++;
    if (clr) begin m_ovf = 0; m_unf = 0; end
    if (c % FRAME == 0) begin
      if (q.size() == 0) begin m_unf = 1; s = last; end
      else begin s = q.pop_front(); last = s; end
      w_prev = w_cur;
      w_cur  = {s, s};
    end
    if (v) begin
      if (q.size() < DEPTH) q.push_back(d);
      else m_ovf = 1;
    end
    #1;
    sample_valid = 0; clear_flags = 0;
  endtask

  task automatic test_reset();
    sample_valid = 0; clear_flags = 0; sample_in = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (dut_vec() !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_state dut=%b want=%b", dut_vec(), 9'd0);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_idle();
    repeat (2 * FRAME + 20) begin
      step(0, '0, 0);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL idle c=%0d dut=%b model=%b", c, dut_vec(), exp_vec());
      end
      if (c == FRAME - 1 || c == FRAME) begin
        vectors++;
        if (unf !== (c == FRAME)) begin
          miscompares++;
          $display("FAIL idle_first_underflow c=%0d got %b want %b", c, unf, (c == FRAME));
        end
      end
    end
  endtask

  task automatic test_single();
    step(1, 16'h8001, 1);
    repeat (2 * FRAME + 40) begin
      step(0, '0, 0);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL single c=%0d dut=%b model=%b", c, dut_vec(), exp_vec());
      end
      if (w_cur == 32'h8001_8001 && (c / FALL) % SLOTS == 1 && c % FALL == 0) begin
        vectors++;
        if (sdata !== 1'b1) begin
          miscompares++;
          $display("FAIL single_msb c=%0d got %b want 1", c, sdata);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] d;
    step(0, '0, 1);
    while (c % FRAME != 10) begin
      step(0, '0, 0);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL ovf_wait c=%0d dut=%b model=%b", c, dut_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 9; i++) begin
      d = 16'($urandom);
      step(1, d, 0);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL ovf_push%0d dut=%b model=%b", i, dut_vec(), exp_vec());
      end
    end
    vectors++;
    if (level !== 4'd8 || ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_full level=%0d ovf=%b want level=8 ovf=1", level, ovf);
    end
  endtask

  task automatic test_full_push_pop();
    step(0, '0, 1);
    while (c % FRAME != FRAME - 1) begin
      step(0, '0, 0);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL fullpp_wait c=%0d dut=%b model=%b", c, dut_vec(), exp_vec());
      end
    end
    step(1, 16'($urandom), 0);
    vectors++;
    if (level !== 4'd8 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL full_push_pop level=%0d ovf=%b want level=8 ovf=0", level, ovf);
    end
    step(1, 16'($urandom), 0);
    vectors++;
    if (level !== 4'd8 || ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL full_push_nopop level=%0d ovf=%b want level=8 ovf=1", level, ovf);
    end
    repeat (9 * FRAME + 5) begin
      step(0, '0, 0);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL drain c=%0d dut=%b model=%b", c, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_empty_push_pop();
    step(0, '0, 1);
    while (c % FRAME != FRAME - 1) begin
      step(0, '0, 0);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL emptypp_wait c=%0d dut=%b model=%b", c, dut_vec(), exp_vec());
      end
    end
    step(1, 16'h1234, 0);
    vectors++;
    if (unf !== 1'b1 || level !== 4'd1) begin
      miscompares++;
      $display("FAIL empty_push_pop unf=%b level=%0d want unf=1 level=1", unf, level);
    end
    repeat (2 * FRAME) begin
      step(0, '0, 0);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL emptypp c=%0d dut=%b model=%b", c, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic v, clr;
    repeat (6 * FRAME) begin
      v   = ($urandom_range(0, 199) == 0);
      clr = ($urandom_range(0, 499) == 0);
      step(v, 16'($urandom), clr);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random c=%0d dut=%b model=%b", c, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_mid_reset();
    step(1, 16'($urandom), 0);
    while ((c / FALL) % SLOTS != 20) begin
      step(0, '0, 0);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL mreset_wait c=%0d dut=%b model=%b", c, dut_vec(), exp_vec());
      end
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (dut_vec() !== 9'd0) begin
      miscompares++;
      $display("FAIL mid_reset dut=%b want=%b", dut_vec(), 9'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    repeat (FRAME + 30) begin
      step(($urandom_range(0, 99) == 0), 16'($urandom), 0);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL after_reset c=%0d dut=%b model=%b", c, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
